// File: rtl/instr_sequencer.sv
// instr_sequencer: feeds 9-bit instructions from a small writable program memory to the
// processor core, one at a time, handshaking with the core's completion pulse.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   prog_we/addr/data/last       program write port (honoured only in IDLE)
//   run, step_mode, step_req     execution control
//   proc_done                    completion pulse from the core (sampled only in WAIT)
//   din                          registered instruction word to the core
//   tick_ena                     one-cycle start pulse to the core tick FSM
//   pc                           address of the current/next instruction
//   busy, halted, fault          status (fault is the sticky watchdog flag)
module instr_sequencer #(
  parameter int unsigned IW      = 9,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          prog_last,
  input  logic          run,
  input  logic          step_mode,
  input  logic          step_req,
  input  logic          proc_done,
  output logic [IW-1:0] din,
  output logic          tick_ena,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          fault
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StPause,
    StHalt
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] din_q, din_d;
  logic          last_q, last_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          fault_q, fault_d;
  logic          tick_q, tick_d;
  logic          mem_we;
  logic [AW-1:0] pc_next;

  // Stop bit lives in the MSB of each word.
  logic [IW:0]   mem_q [DEPTH];

  assign pc_next = (pc_q == AW'(DEPTH - 1)) ? '0 : pc_q + AW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    fault_d = fault_q;
    tick_d  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A write in the same cycle as run takes priority; launch waits a cycle.
        if (prog_we) begin
          mem_we = 1'b1;
        end else if (run) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        din_d   = mem_q[pc_q][IW-1:0];
        last_d  = mem_q[pc_q][IW];
        state_d = StIssue;
      end
      StIssue: begin
        tick_d  = 1'b1;
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion on the timeout cycle counts as normal completion.
        if (proc_done) begin
          if (last_q) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_next;
            if (!run) begin
              state_d = StIdle;
            end else if (step_mode) begin
              state_d = StPause;
            end else begin
              state_d = StFetch;
            end
          end
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      StPause: begin
        if (!run) begin
          state_d = StIdle;
        end else if (step_req || !step_mode) begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (!run) begin
          state_d = StIdle;
          fault_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // pc reads 0 as soon as the sequencer is back in IDLE.
    if (state_d == StIdle) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      din_q   <= '0;
      last_q  <= 1'b0;
      wdog_q  <= '0;
      fault_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
      tick_q  <= tick_d;
    end
  end

  // Program memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[prog_addr] <= {prog_last, prog_data};
    end
  end

  assign din      = din_q;
  assign tick_ena = tick_q;
  assign pc       = pc_q;
  assign busy     = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait);
  assign halted   = (state_q == StHalt);
  assign fault    = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [8:0] prog_data;
  logic       prog_last;
  logic       run;
  logic       step_mode;
  logic       step_req;
  logic       proc_done;
  logic [8:0] din;
  logic       tick_ena;
  logic [3:0] pc;
  logic       busy;
  logic       halted;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;
  int consec = 0;
  int t0;
  logic tick_prev = 1'b0;

  logic [8:0] prog16 [16] = '{9'h101, 9'h0A2, 9'h1F3, 9'h034, 9'h145, 9'h0D6, 9'h067, 9'h1B8,
                              9'h009, 9'h11A, 9'h0EB, 9'h07C, 9'h18D, 9'h02E, 9'h15F, 9'h0C0};

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_last (prog_last),
    .run       (run),
    .step_mode (step_mode),
    .step_req  (step_req),
    .proc_done (proc_done),
    .din       (din),
    .tick_ena  (tick_ena),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Counts tick_ena pulses and any back-to-back assertion.
  always @(posedge clk) begin
    if (tick_ena) tick_cnt <= tick_cnt + 1;
    if (tick_ena && tick_prev) consec <= consec + 1;
    tick_prev <= tick_ena;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [8:0] d, input logic l);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    prog_last = l;
    cyc(1);
    prog_we   = 1'b0;
    prog_last = 1'b0;
  endtask

  // Returns at the falling edge where tick_ena is high (first WAIT cycle).
  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc(1);
      if (tick_ena) seen = 1'b1;
    end
    if (!seen) check_eq({tag, "_tick_timeout"}, 32'd0, 32'd1);
  endtask

  // Completion pulse in the fourth WAIT cycle; returns one cycle after it was sampled.
  task automatic done_after;
    cyc(3);
    proc_done = 1'b1;
    cyc(1);
    proc_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_last = 1'b0;
    run = 1'b0; step_mode = 1'b0; step_req = 1'b0; proc_done = 1'b0;
    cyc(3);
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_din", 32'(din), 32'h0);
    check_eq("rst_tick", 32'(tick_ena), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    check_eq("rst_fault", 32'(fault), 32'h0);
    rst = 1'b0;
    cyc(1);

    // Three-word program, last word halts.
    load(4'd0, 9'h1C5, 1'b0);
    load(4'd1, 9'h049, 1'b0);
    load(4'd2, 9'h000, 1'b1);
    t0 = tick_cnt;
    run = 1'b1;
    cyc(1);
    check_eq("lat_fetch_busy", 32'(busy), 32'h1);
    check_eq("lat_fetch_tick", 32'(tick_ena), 32'h0);
    cyc(1);
    check_eq("lat_issue_din", 32'(din), 32'h1C5);
    check_eq("lat_issue_tick", 32'(tick_ena), 32'h0);
    cyc(1);
    check_eq("lat_tick", 32'(tick_ena), 32'h1);
    done_after();
    wait_tick("p3_w1");
    check_eq("p3_din1", 32'(din), 32'h049);
    done_after();
    wait_tick("p3_w2");
    check_eq("p3_din2", 32'(din), 32'h000);
    done_after();
    check_eq("p3_halted", 32'(halted), 32'h1);
    check_eq("p3_pc", 32'(pc), 32'h2);
    check_eq("p3_busy", 32'(busy), 32'h0);
    cyc(5);
    check_eq("p3_halt_hold", 32'(halted), 32'h1);
    check_eq("p3_ticks", 32'(tick_cnt - t0), 32'd3);
    run = 1'b0;
    cyc(1);
    check_eq("p3_idle_pc", 32'(pc), 32'h0);
    check_eq("p3_idle_halted", 32'(halted), 32'h0);

    // Sixteen words, none last: pc wraps after the last address.
    for (int i = 0; i < 16; i++) load(4'(i), prog16[i], 1'b0);
    run = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_tick("wrap");
      check_eq($sformatf("wrap_din%0d", k), 32'(din), 32'(prog16[k]));
      done_after();
      check_eq($sformatf("wrap_pc%0d", k), 32'(pc), 32'((k + 1) % 16));
    end
    wait_tick("wrap17");
    check_eq("wrap_din16", 32'(din), 32'h101);
    // Drop run and attempt a write while waiting on the core.
    run = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 9'h1FF; prog_last = 1'b1;
    cyc(1);
    prog_we = 1'b0; prog_last = 1'b0;
    cyc(1);
    check_eq("rundrop_busy", 32'(busy), 32'h1);
    proc_done = 1'b1;
    cyc(1);
    proc_done = 1'b0;
    check_eq("rundrop_busy_idle", 32'(busy), 32'h0);
    check_eq("rundrop_pc", 32'(pc), 32'h0);
    t0 = tick_cnt;
    cyc(6);
    check_eq("rundrop_noticks", 32'(tick_cnt - t0), 32'd0);
    run = 1'b1;
    wait_tick("rerun0");
    check_eq("rerun_din0", 32'(din), 32'h101);
    done_after();
    wait_tick("rerun1");
    check_eq("rerun_din1_unchanged", 32'(din), 32'h0A2);
    run = 1'b0;
    done_after();
    check_eq("rerun_idle_busy", 32'(busy), 32'h0);
    check_eq("rerun_idle_halted", 32'(halted), 32'h0);

    // Single-step mode.
    load(4'd0, 9'h0AA, 1'b0);
    load(4'd1, 9'h155, 1'b1);
    step_mode = 1'b1;
    run = 1'b1;
    wait_tick("step0");
    check_eq("step_din0", 32'(din), 32'h0AA);
    done_after();
    check_eq("step_pause_busy", 32'(busy), 32'h0);
    check_eq("step_pause_pc", 32'(pc), 32'h1);
    t0 = tick_cnt;
    cyc(5);
    check_eq("step_pause_noticks", 32'(tick_cnt - t0), 32'd0);
    check_eq("step_pause_halted", 32'(halted), 32'h0);
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    check_eq("step_fetch_busy", 32'(busy), 32'h1);
    cyc(1);
    check_eq("step_din1", 32'(din), 32'h155);
    wait_tick("step1");
    done_after();
    check_eq("step_halted", 32'(halted), 32'h1);
    check_eq("step_halt_pc", 32'(pc), 32'h1);
    run = 1'b0;
    step_mode = 1'b0;
    cyc(1);
    check_eq("step_idle_pc", 32'(pc), 32'h0);

    // Watchdog: no completion for the full window.
    load(4'd0, 9'h123, 1'b0);
    run = 1'b1;
    wait_tick("wd");
    cyc(14);
    check_eq("wd_pre_halted", 32'(halted), 32'h0);
    check_eq("wd_pre_fault", 32'(fault), 32'h0);
    cyc(1);
    check_eq("wd_halted", 32'(halted), 32'h1);
    check_eq("wd_fault", 32'(fault), 32'h1);
    check_eq("wd_pc", 32'(pc), 32'h0);
    check_eq("wd_din", 32'(din), 32'h123);
    proc_done = 1'b1;
    cyc(1);
    proc_done = 1'b0;
    check_eq("wd_done_ignored", 32'(halted), 32'h1);
    check_eq("wd_fault_sticky", 32'(fault), 32'h1);
    run = 1'b0;
    cyc(1);
    check_eq("wd_idle_fault", 32'(fault), 32'h0);
    check_eq("wd_idle_halted", 32'(halted), 32'h0);
    check_eq("wd_idle_pc", 32'(pc), 32'h0);

    // Completion on the timeout cycle is a normal completion.
    run = 1'b1;
    wait_tick("wdtie");
    cyc(14);
    proc_done = 1'b1;
    run = 1'b0;
    cyc(1);
    proc_done = 1'b0;
    check_eq("wdtie_fault", 32'(fault), 32'h0);
    check_eq("wdtie_halted", 32'(halted), 32'h0);
    check_eq("wdtie_busy", 32'(busy), 32'h0);

    // Reset while in ISSUE.
    run = 1'b1;
    cyc(2);
    check_eq("rstiss_tick_pre", 32'(tick_ena), 32'h0);
    rst = 1'b1;
    cyc(1);
    check_eq("rstiss_tick", 32'(tick_ena), 32'h0);
    check_eq("rstiss_busy", 32'(busy), 32'h0);
    check_eq("rstiss_din", 32'(din), 32'h0);
    check_eq("rstiss_pc", 32'(pc), 32'h0);
    check_eq("rstiss_fault", 32'(fault), 32'h0);
    rst = 1'b0;
    run = 1'b0;
    cyc(3);
    check_eq("tick_never_consecutive", 32'(consec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
